// File: rtl/four_input_gate_exerciser.sv
// Sweeps all 16 input vectors through an external 4-input gate and checks
// each response against the selected NAND/NOR/XOR/XNOR reference.
module four_input_gate_exerciser #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] func_sel,
    input  logic       gate_out,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [4:0] err_count,
    output logic [3:0] first_fail_vec,
    output logic       first_fail_valid
);

    localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    function automatic logic ref_gate(input logic [1:0] f, input logic [3:0] v);
        logic r;
        case (f)
            2'b00:   r = ~&v;
            2'b01:   r = ~|v;
            2'b10:   r = ^v;
            2'b11:   r = ~^v;
            default: r = ~&v;
        endcase
        return r;
    endfunction

    state_t           state_q, state_d;
    logic [3:0]       vec_q, vec_d;
    logic [1:0]       func_q, func_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [4:0]       err_q, err_d;
    logic [3:0]       ffv_q, ffv_d;
    logic             ffvalid_q, ffvalid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    // Next-state and next-result computation for the sweep FSM.
    always_comb begin
        state_d   = state_q;
        vec_d     = vec_q;
        func_d    = func_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_SETTLE;
                    vec_d     = 4'd0;
                    func_d    = func_sel;
                    cnt_d     = '0;
                    err_d     = 5'd0;
                    ffv_d     = 4'd0;
                    ffvalid_d = 1'b0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            S_SETTLE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d = S_SAMPLE;
                end else begin
                    state_d = S_SETTLE;
                end
            end
            S_SAMPLE: begin
                if (gate_out != ref_gate(func_q, vec_q)) begin
                    err_d = err_q + 5'd1;
                    if (!ffvalid_q) begin
                        ffv_d     = vec_q;
                        ffvalid_d = 1'b1;
                    end else begin
                        ffv_d     = ffv_q;
                    end
                end else begin
                    err_d = err_q;
                end
                // The final sample's mismatch is folded into pass here.
                if (vec_q == 4'hF) begin
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_d == 5'd0);
                end else begin
                    state_d = S_SETTLE;
                    vec_d   = vec_q + 4'd1;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
                pass_d  = 1'b0;
            end
        endcase
    end

    // State and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            vec_q     <= 4'd0;
            func_q    <= 2'd0;
            cnt_q     <= '0;
            err_q     <= 5'd0;
            ffv_q     <= 4'd0;
            ffvalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vec_q     <= vec_d;
            func_q    <= func_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign {a, b, c, d}     = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffvalid_q;

endmodule
